// File: rtl/stim_pkg.sv
// Shared types and constants for the stimulus sequencer.
// Entry layout is {hold, vector} with the vector in the LSBs.
package stim_pkg;

   typedef enum logic {
      IDLE,
      PLAY
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_LEN,
      ERR_WR_BUSY,
      ERR_WR_ADDR
   } err_e;

   localparam int VEC_LSB = 0;

   function automatic int hold_lsb(input int vec_w);
      return VEC_LSB + vec_w;
   endfunction

endpackage

// File: rtl/stim_ram.sv
// Program store: one synchronous write port, asynchronous read.
// Contents are deliberately not reset.
module stim_ram
   import stim_pkg::*;
#(
   parameter int DEPTH  = 31,
   parameter int W      = 11,
   parameter int ADDR_W = 5
) (
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [W-1:0]      wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [W-1:0]      rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/stim_player.sv
// Stimulus sequencer: plays {hold, vector} entries onto vec_out,
// one-shot or looped, with abort and run-time program loading.
module stim_player
   import stim_pkg::*;
#(
   parameter int VEC_W  = 3,
   parameter int DEPTH  = 31,
   parameter int HOLD_W = 8,
   parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [VEC_W+HOLD_W-1:0] wr_data,
   input  logic                    start,
   input  logic [ADDR_W:0]         len,
   input  logic                    loop_en,
   input  logic                    stop,
   output logic [VEC_W-1:0]        vec_out,
   output logic [ADDR_W-1:0]       pc,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [31:0]             cyc_cnt
);

   localparam int W        = VEC_W + HOLD_W;
   localparam int HOLD_LSB = hold_lsb(VEC_W);
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   state_e              state_q, state_n;
   logic [VEC_W-1:0]    vec_q, vec_n;
   logic [HOLD_W-1:0]   hold_q, hold_n;
   logic [ADDR_W-1:0]   pc_q, pc_n;
   logic [ADDR_W:0]     len_q, len_n;
   logic [31:0]         cyc_q, cyc_n;
   logic                done_n;
   err_e                err_cause;
   logic                err_q;

   logic                wr_ok;
   logic                len_ok;
   logic                at_last;
   logic [ADDR_W-1:0]   rd_addr;
   logic [W-1:0]        ram_q;
   logic [W-1:0]        rd_word;
   logic [VEC_W-1:0]    rd_vec;
   logic [HOLD_W-1:0]   rd_hold;

   assign wr_ok   = wr_en && (state_q == IDLE)
                 && ({1'b0, wr_addr} < DEPTH_L);
   assign len_ok  = (len != '0) && (len <= DEPTH_L);
   assign at_last = ({1'b0, pc_q} == len_q - (ADDR_W+1)'(1));
   assign rd_addr = (state_q == IDLE || at_last)
                  ? '0 : pc_q + ADDR_W'(1);

   stim_ram #(
      .DEPTH  (DEPTH),
      .W      (W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clock (clock),
      .we    (wr_ok),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (rd_addr),
      .rdata (ram_q)
   );

   // Bypass so a start in the same cycle as a write sees the new entry.
   assign rd_word = (wr_ok && wr_addr == rd_addr) ? wr_data : ram_q;
   assign rd_vec  = rd_word[VEC_LSB +: VEC_W];
   assign rd_hold = rd_word[HOLD_LSB +: HOLD_W];

   always_comb begin
      state_n   = state_q;
      vec_n     = vec_q;
      hold_n    = hold_q;
      pc_n      = pc_q;
      len_n     = len_q;
      cyc_n     = cyc_q;
      done_n    = 1'b0;
      err_cause = ERR_NONE;
      if (wr_en && !wr_ok) begin
         err_cause = (state_q == PLAY) ? ERR_WR_BUSY : ERR_WR_ADDR;
      end
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (len_ok) begin
                  state_n = PLAY;
                  vec_n   = rd_vec;
                  hold_n  = rd_hold;
                  pc_n    = '0;
                  len_n   = len;
                  cyc_n   = 32'd1;
               end else begin
                  err_cause = ERR_LEN;
               end
            end
         end
         PLAY: begin
            if (stop) begin
               state_n = IDLE;
               vec_n   = '0;
            end else if (hold_q != '0) begin
               hold_n = hold_q - HOLD_W'(1);
               cyc_n  = cyc_q + 32'd1;
            end else if (!at_last || loop_en) begin
               pc_n   = rd_addr;
               vec_n  = rd_vec;
               hold_n = rd_hold;
               cyc_n  = cyc_q + 32'd1;
            end else begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         vec_q   <= '0;
         hold_q  <= '0;
         pc_q    <= '0;
         len_q   <= '0;
         cyc_q   <= '0;
         done    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         vec_q   <= vec_n;
         hold_q  <= hold_n;
         pc_q    <= pc_n;
         len_q   <= len_n;
         cyc_q   <= cyc_n;
         done    <= done_n;
         err_q   <= (err_cause != ERR_NONE);
      end
   end

   assign vec_out = vec_q;
   assign pc      = pc_q;
   assign busy    = (state_q == PLAY);
   assign err     = err_q;
   assign cyc_cnt = cyc_q;

endmodule

// File: tb/tb_stim_player.sv
// Directed plus randomized bench for stim_player against an
// expanded-program reference model.
module tb_stim_player;

   localparam int VEC_W  = 3;
   localparam int DEPTH  = 31;
   localparam int HOLD_W = 8;
   localparam int ADDR_W = 5;

   logic                    clock = 1'b0;
   logic                    reset;
   logic                    wr_en;
   logic [ADDR_W-1:0]       wr_addr;
   logic [VEC_W+HOLD_W-1:0] wr_data;
   logic                    start;
   logic [ADDR_W:0]         len;
   logic                    loop_en;
   logic                    stop;
   logic [VEC_W-1:0]        vec_out;
   logic [ADDR_W-1:0]       pc;
   logic                    busy;
   logic                    done;
   logic                    err;
   logic [31:0]             cyc_cnt;

   int nchk = 0;
   int nerr = 0;

   logic [VEC_W-1:0]  m_vec  [DEPTH];
   logic [HOLD_W-1:0] m_hold [DEPTH];
   int expv[$];
   int expp[$];

   stim_player dut (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .start   (start),
      .len     (len),
      .loop_en (loop_en),
      .stop    (stop),
      .vec_out (vec_out),
      .pc      (pc),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .cyc_cnt (cyc_cnt)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic put(input int a, input int h, input int v);
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(a);
      wr_data = {HOLD_W'(h), VEC_W'(v)};
      m_hold[a] = HOLD_W'(h);
      m_vec[a]  = VEC_W'(v);
      tick();
      wr_en = 1'b0;
   endtask

   task automatic build(input int n);
      expv.delete();
      expp.delete();
      for (int i = 0; i < n; i++)
         for (int h = 0; h <= int'(m_hold[i]); h++) begin
            expv.push_back(int'(m_vec[i]));
            expp.push_back(i);
         end
   endtask

   task automatic play(input int n, input int cycles, input bit oneshot);
      int sz;
      build(n);
      sz = expv.size();
      start = 1'b1;
      len   = (ADDR_W+1)'(n);
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      for (int k = 0; k < cycles; k++) begin
         check("vec", 32'(vec_out), 32'(expv[k % sz]));
         check("pc", 32'(pc), 32'(expp[k % sz]));
         check("busy", 32'(busy), 32'd1);
         check("done_run", 32'(done), 32'd0);
         check("cyc", cyc_cnt, 32'(k + 1));
         tick();
      end
      if (oneshot) begin
         check("done", 32'(done), 32'd1);
         check("busy_end", 32'(busy), 32'd0);
         check("cyc_end", cyc_cnt, 32'(sz));
         check("vec_end", 32'(vec_out), 32'(expv[sz-1]));
         tick();
         check("done_pulse", 32'(done), 32'd0);
      end
   endtask

   task automatic idle_zero(input string tag);
      check({tag, "_vec"}, 32'(vec_out), 32'd0);
      check({tag, "_pc"}, 32'(pc), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_err"}, 32'(err), 32'd0);
      check({tag, "_cyc"}, cyc_cnt, 32'd0);
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; len = '0; loop_en = 1'b0; stop = 1'b0;
      tick(); tick();
      reset = 1'b0;
      idle_zero("reset");

      // Reference program from the test plan
      put(0, 0, 1); put(1, 2, 2); put(2, 0, 4);
      play(3, 5, 1'b1);

      loop_en = 1'b1;
      play(3, 12, 1'b0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      loop_en = 1'b0;
      check("stop_vec", 32'(vec_out), 32'd0);
      check("stop_busy", 32'(busy), 32'd0);
      check("stop_done", 32'(done), 32'd0);

      // Length bounds
      start = 1'b1; len = '0;
      tick();
      start = 1'b0;
      check("len0_err", 32'(err), 32'd1);
      check("len0_busy", 32'(busy), 32'd0);
      tick();
      check("len0_err_pulse", 32'(err), 32'd0);
      start = 1'b1; len = (ADDR_W+1)'(DEPTH + 1);
      tick();
      start = 1'b0;
      check("lenbig_err", 32'(err), 32'd1);
      check("lenbig_busy", 32'(busy), 32'd0);

      // Out-of-range write address
      wr_en = 1'b1; wr_addr = ADDR_W'(DEPTH); wr_data = '1;
      tick();
      wr_en = 1'b0;
      check("wraddr_err", 32'(err), 32'd1);

      for (int i = 0; i < DEPTH; i++) put(i, 0, int'($urandom_range(7)));
      play(DEPTH, DEPTH, 1'b1);

      put(0, 255, int'($urandom_range(1, 7)));
      play(1, 256, 1'b1);

      for (int r = 0; r < 6; r++) begin
         int n;
         n = int'($urandom_range(1, 8));
         for (int i = 0; i < n; i++)
            put(i, int'($urandom_range(3)), int'($urandom_range(7)));
         play(n, expv.size() * 0 + 0, 1'b0);
         stop = 1'b1; tick(); stop = 1'b0;
         play(n, expv.size(), 1'b1);
      end

      // Write attempt while playing must be dropped
      put(0, 0, 1); put(1, 2, 2); put(2, 0, 4);
      start = 1'b1; len = 6'd3;
      tick();
      start = 1'b0;
      wr_en = 1'b1; wr_addr = '0; wr_data = {8'd0, 3'b111};
      tick();
      wr_en = 1'b0;
      check("wrplay_err", 32'(err), 32'd1);
      check("wrplay_busy", 32'(busy), 32'd1);
      stop = 1'b1; tick(); stop = 1'b0;
      check("wrplay_stop", 32'(busy), 32'd0);
      play(3, 5, 1'b1);

      // Same-cycle write of entry 0 with start
      wr_en = 1'b1; wr_addr = '0; wr_data = {8'd1, 3'b110};
      m_hold[0] = 8'd1; m_vec[0] = 3'b110;
      play(3, 6, 1'b1);

      // Reset in the middle of a held entry
      put(0, 4, 5);
      start = 1'b1; len = 6'd1;
      tick();
      start = 1'b0;
      tick(); tick();
      check("midhold_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      idle_zero("midreset");
      play(1, 5, 1'b1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
